// File: rtl/inst_buffer.sv
// Dual-read instruction queue between a single-write fetch stage and a dual-issue dispatch stage.
// Latency: a write is visible on rline1 next cycle; with IB_BYPASS_EN it is visible the same cycle when the queue is empty.
// Backpressure: a write is dropped while ib_full; pops are clamped to the occupancy.
module inst_buffer #(
    parameter int DEPTH   = 16,
    parameter int PTR_WD  = 4,
    parameter int LINE_WD = 67
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ib_flush,
    input  logic               ib_write_req,
    input  logic [31:0]        ib_pc,
    input  logic [31:0]        ib_inst,
    input  logic [2:0]         ib_exc,
    output logic               ib_full,
    input  logic               ib_fetch_req,
    input  logic [1:0]         ib_pop_cnt,
    output logic [LINE_WD-1:0] ib_rline1,
    output logic [LINE_WD-1:0] ib_rline2,
    output logic               ib_rvalid1,
    output logic               ib_rvalid2,
    output logic               ib_empty,
    output logic [PTR_WD:0]    ib_count
);

    localparam logic [PTR_WD:0] FULL_CNT = (PTR_WD+1)'(DEPTH);

    logic [LINE_WD-1:0] mem [DEPTH];
    logic [PTR_WD-1:0]  head;
    logic [PTR_WD-1:0]  tail;
    logic [PTR_WD-1:0]  head_p1;
    logic [PTR_WD:0]    count;
    logic [PTR_WD:0]    count_nxt;
    logic [LINE_WD-1:0] wr_line;
    logic               push;
    logic               bypass;
    logic               store;
    logic [1:0]         pop_req;
    logic [1:0]         pop;

    assign wr_line = LINE_WD'({ib_exc, ib_pc, ib_inst});
    assign push    = ib_write_req & ~ib_full & ~ib_flush;
    assign pop_req = !ib_fetch_req        ? 2'd0 :
                     (ib_pop_cnt == 2'd3) ? 2'd2 : ib_pop_cnt;

`ifdef IB_BYPASS_EN
    assign bypass = push & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    // Clamp the pop to what the read port is actually presenting.
    always_comb begin
        pop = pop_req;
        if (bypass) begin
            pop = (pop_req != 2'd0) ? 2'd1 : 2'd0;
        end else if (count == '0) begin
            pop = 2'd0;
        end else if ((count == (PTR_WD+1)'(1)) && (pop_req == 2'd2)) begin
            pop = 2'd1;
        end
    end

    // A bypassed line consumed on arrival never needs to land in storage.
    assign store     = push & ~(bypass & (pop != 2'd0));
    assign count_nxt = count + (PTR_WD+1)'(push) - (PTR_WD+1)'(pop);
    assign head_p1   = head + PTR_WD'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (ib_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_WD'(pop);
            tail  <= tail + PTR_WD'(push);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[tail] <= wr_line;
        end
    end

    assign ib_full    = (count == FULL_CNT);
    assign ib_count   = count;
    assign ib_rvalid1 = (count != '0) | bypass;
    assign ib_rvalid2 = (count >= (PTR_WD+1)'(2));
    assign ib_empty   = (count == '0) & ~bypass;
    assign ib_rline1  = bypass ? wr_line : mem[head];
    assign ib_rline2  = mem[head_p1];

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: vector table plus hand sequences for reset, fill/drain, wrap and bypass.
module tb_inst_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ib_flush, ib_write_req, ib_fetch_req;
    logic [31:0] ib_pc, ib_inst;
    logic [2:0]  ib_exc;
    logic [1:0]  ib_pop_cnt;
    logic        ib_full, ib_rvalid1, ib_rvalid2, ib_empty;
    logic [66:0] ib_rline1, ib_rline2;
    logic [4:0]  ib_count;

    int n_cmp = 0;
    int n_err = 0;

    inst_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .ib_flush     (ib_flush),
        .ib_write_req (ib_write_req),
        .ib_pc        (ib_pc),
        .ib_inst      (ib_inst),
        .ib_exc       (ib_exc),
        .ib_full      (ib_full),
        .ib_fetch_req (ib_fetch_req),
        .ib_pop_cnt   (ib_pop_cnt),
        .ib_rline1    (ib_rline1),
        .ib_rline2    (ib_rline2),
        .ib_rvalid1   (ib_rvalid1),
        .ib_rvalid2   (ib_rvalid2),
        .ib_empty     (ib_empty),
        .ib_count     (ib_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic        wr;
        logic [31:0] pc;
        logic        fr;
        logic [1:0]  pcnt;
        logic [4:0]  cnt;
        logic        c1;
        logic [31:0] p1;
        logic        c2;
        logic [31:0] p2;
    } vec_t;

    vec_t tv [16];

    function automatic logic [66:0] mk_line(input logic [31:0] pc);
        return {pc[4:2], pc, ~pc};
    endfunction

    function automatic vec_t mkv(input logic fl, input logic wr, input logic [31:0] pc,
                                 input logic fr, input logic [1:0] pcnt, input logic [4:0] cnt,
                                 input logic c1, input logic [31:0] p1,
                                 input logic c2, input logic [31:0] p2);
        vec_t v;
        v.fl = fl; v.wr = wr; v.pc = pc; v.fr = fr; v.pcnt = pcnt;
        v.cnt = cnt; v.c1 = c1; v.p1 = p1; v.c2 = c2; v.p2 = p2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm, input logic [4:0] c);
        chk({nm, ".count"}, 67'(ib_count), 67'(c));
        chk({nm, ".empty"}, 67'(ib_empty), 67'(c == 5'd0));
        chk({nm, ".full"}, 67'(ib_full), 67'(c == 5'd16));
        chk({nm, ".rvalid1"}, 67'(ib_rvalid1), 67'(c != 5'd0));
        chk({nm, ".rvalid2"}, 67'(ib_rvalid2), 67'(c >= 5'd2));
    endtask

    task automatic drive(input logic fl, input logic wr, input logic [31:0] pc,
                         input logic fr, input logic [1:0] pcnt);
        ib_flush     = fl;
        ib_write_req = wr;
        ib_pc        = pc;
        ib_inst      = ~pc;
        ib_exc       = pc[4:2];
        ib_fetch_req = fr;
        ib_pop_cnt   = pcnt;
    endtask

    // Apply one cycle of inputs, then return to idle just after the edge.
    task automatic step(input logic fl, input logic wr, input logic [31:0] pc,
                        input logic fr, input logic [1:0] pcnt);
        drive(fl, wr, pc, fr, pcnt);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    endtask

    localparam logic [31:0] C0 = 32'h0040_0000;
    localparam logic [31:0] B0 = 32'hBFC0_0000;
    localparam logic [31:0] E0 = 32'h9000_0000;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd0);

        tv[0]  = mkv(0, 1, C0 + 0,  0, 0, 1, 1, C0 + 0,  0, 0);
        tv[1]  = mkv(0, 1, C0 + 4,  0, 0, 2, 1, C0 + 0,  1, C0 + 4);
        tv[2]  = mkv(0, 1, C0 + 8,  1, 1, 2, 1, C0 + 4,  1, C0 + 8);
        tv[3]  = mkv(0, 0, 0,       1, 3, 0, 0, 0,       0, 0);
        tv[4]  = mkv(0, 1, C0 + 12, 0, 2, 1, 1, C0 + 12, 0, 0);
        tv[5]  = mkv(0, 1, C0 + 16, 1, 2, 1, 1, C0 + 16, 0, 0);
        tv[6]  = mkv(0, 0, 0,       1, 2, 0, 0, 0,       0, 0);
        tv[7]  = mkv(0, 1, C0 + 20, 0, 0, 1, 1, C0 + 20, 0, 0);
        tv[8]  = mkv(0, 1, C0 + 24, 0, 0, 2, 1, C0 + 20, 1, C0 + 24);
        tv[9]  = mkv(0, 1, C0 + 28, 0, 0, 3, 1, C0 + 20, 1, C0 + 24);
        tv[10] = mkv(0, 1, C0 + 32, 0, 0, 4, 1, C0 + 20, 1, C0 + 24);
        tv[11] = mkv(0, 1, C0 + 36, 0, 0, 5, 1, C0 + 20, 1, C0 + 24);
        tv[12] = mkv(0, 1, C0 + 40, 0, 0, 6, 1, C0 + 20, 1, C0 + 24);
        tv[13] = mkv(1, 1, C0 + 44, 1, 2, 0, 0, 0,       0, 0);
        tv[14] = mkv(0, 1, C0 + 48, 0, 0, 1, 1, C0 + 48, 0, 0);
        tv[15] = mkv(0, 1, C0 + 52, 0, 0, 2, 1, C0 + 48, 1, C0 + 52);

        #12 reset = 1'b0;
        @(posedge clk);
        #1;
        check_state("reset", 5'd0);

        for (int i = 0; i < 16; i++) begin
            step(tv[i].fl, tv[i].wr, tv[i].pc, tv[i].fr, tv[i].pcnt);
            check_state($sformatf("vec%0d", i), tv[i].cnt);
            if (tv[i].c1) chk($sformatf("vec%0d.rline1", i), ib_rline1, mk_line(tv[i].p1));
            if (tv[i].c2) chk($sformatf("vec%0d.rline2", i), ib_rline2, mk_line(tv[i].p2));
        end

        // Steer head to DEPTH-1 with three entries, then dual-pop across the wrap.
        step(0, 0, 0, 1, 2);
        check_state("wrap.drain", 5'd0);
        step(0, 1, E0, 0, 0);
        for (int k = 1; k <= 13; k++) step(0, 1, E0 + 32'(4 * k), 1, 1);
        step(0, 1, E0 + 56, 0, 0);
        step(0, 1, E0 + 60, 0, 0);
        check_state("wrap.pre", 5'd3);
        chk("wrap.rline1", ib_rline1, mk_line(E0 + 52));
        chk("wrap.rline2", ib_rline2, mk_line(E0 + 56));
        step(0, 0, 0, 1, 2);
        check_state("wrap.post", 5'd1);
        chk("wrap.post.rline1", ib_rline1, mk_line(E0 + 60));
        step(0, 0, 0, 1, 1);
        check_state("wrap.empty", 5'd0);

        // Write into an empty queue while requesting a pop in the same cycle.
        drive(0, 1, 32'h8000_0000, 1, 1);
        #1;
`ifdef IB_BYPASS_EN
        chk("bypass.rvalid1", 67'(ib_rvalid1), 67'(1));
        chk("bypass.empty", 67'(ib_empty), 67'(0));
        chk("bypass.rline1", ib_rline1, mk_line(32'h8000_0000));
`else
        chk("bypass.rvalid1", 67'(ib_rvalid1), 67'(0));
        chk("bypass.empty", 67'(ib_empty), 67'(1));
`endif
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
`ifdef IB_BYPASS_EN
        check_state("bypass.next", 5'd0);
`else
        check_state("bypass.next", 5'd1);
        chk("bypass.next.rline1", ib_rline1, mk_line(32'h8000_0000));
`endif

        // Reset in the middle of traffic clears occupancy without waiting for a clock.
        for (int i = 0; i < 5; i++) step(0, 1, C0 + 32'(4 * i), 0, 0);
        reset = 1'b1;
        #1;
        check_state("rst_mid", 5'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_state("rst_mid.after", 5'd0);

        // Fill to full, drop the 17th write, then drain and confirm the sequence.
        for (int i = 0; i < 16; i++) step(0, 1, B0 + 32'(4 * i), 0, 0);
        check_state("fill", 5'd16);
        chk("fill.rline1", ib_rline1, mk_line(B0));
        chk("fill.rline2", ib_rline2, mk_line(B0 + 4));
        step(0, 1, B0 + 32'h40, 0, 0);
        check_state("fill.drop", 5'd16);
        step(0, 1, 32'hDEAD_0000, 1, 1);
        check_state("full_pop", 5'd15);
        for (int k = 1; k < 16; k++) begin
            chk($sformatf("drain%0d.rline1", k), ib_rline1, mk_line(B0 + 32'(4 * k)));
            chk($sformatf("drain%0d.rvalid1", k), 67'(ib_rvalid1), 67'(1));
            step(0, 0, 0, 1, 1);
        end
        check_state("drain.end", 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
